pll_lock_supervisor: RTL

- Parametrised lock supervisor for ECP5 EHXPLLL clock generation. Runs in the PLL reference clock domain (clkin, 25 MHz board oscillator).
- Drives PLL RST and watches the asynchronous LOCK output. Debounces lock, retries on lock timeout, and recovers automatically after loss of lock.
- Releases N per-domain reset requests in sequence, so downstream logic (video timing, sprite engine) only leaves reset on a stable clock.

---
 rtl/pll_sup_pkg.sv | 17 +
 rtl/lock_sync.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and counter-width helper for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StRelease  = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } sup_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL LOCK into the clkin domain.
module lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies lock, retries on timeout and
// releases the downstream domain resets one after another once lock is stable.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOSS_FILTER_CYCLES  = 4,
    parameter int unsigned MAX_RETRIES         = 7,
    parameter int unsigned N_RST               = 2,
    parameter int unsigned RELEASE_GAP         = 8,
    parameter int unsigned CNT_W               = 8
) (
    input  logic                             clkin,
    input  logic                             rst,
    input  logic                             pll_lock_i,
    input  logic                             force_relock,
    output logic                             pll_rst,
    output logic [N_RST-1:0]                 domain_rst,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [CNT_W-1:0]                 loss_count,
    output logic [2:0]                       state_o
);

    localparam int unsigned RetryW      = $clog2(MAX_RETRIES + 1);
    localparam int unsigned RstLast     = PLL_RST_CYCLES - 1;
    localparam int unsigned StableLast  = LOCK_STABLE_CYCLES - 1;
    localparam int unsigned TimeoutLast = LOCK_TIMEOUT_CYCLES - 1;
    localparam int unsigned LossLast    = LOSS_FILTER_CYCLES - 1;
    localparam int unsigned RelLast     = (N_RST - 1) * RELEASE_GAP;
    localparam int unsigned RstW        = cnt_width(RstLast);
    localparam int unsigned StableW     = cnt_width(StableLast);
    localparam int unsigned TimeoutW    = cnt_width(TimeoutLast);
    localparam int unsigned LossW       = cnt_width(LossLast);
    localparam int unsigned RelW        = cnt_width(RelLast);

    logic lock_s;

    sup_state_e          state_q, state_d;
    logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [StableW-1:0]  stable_q, stable_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;
    logic [LossW-1:0]    loss_filt_q, loss_filt_d;
    logic [RelW-1:0]     rel_cnt_q, rel_cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]    loss_cnt_q, loss_cnt_d;

    logic             pll_rst_d, ready_d, fault_d;
    logic [N_RST-1:0] domain_rst_d;
    logic             loss_hit;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (pll_lock_i),
        .q   (lock_s)
    );

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q     <= StResetPll;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            timeout_q   <= '0;
            loss_filt_q <= '0;
            rel_cnt_q   <= '0;
            retry_q     <= '0;
            loss_cnt_q  <= '0;
            pll_rst     <= 1'b1;
            domain_rst  <= '1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            timeout_q   <= timeout_d;
            loss_filt_q <= loss_filt_d;
            rel_cnt_q   <= rel_cnt_d;
            retry_q     <= retry_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst     <= pll_rst_d;
            domain_rst  <= domain_rst_d;
            ready       <= ready_d;
            fault       <= fault_d;
        end
    end

    assign loss_hit = !lock_s && (loss_filt_q == LossW'(LossLast));

    // Phase counters default to zero so every state entry starts them cleanly.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = '0;
        stable_d    = '0;
        timeout_d   = '0;
        loss_filt_d = '0;
        rel_cnt_d   = '0;
        retry_d     = retry_q;
        loss_cnt_d  = loss_cnt_q;

        unique case (state_q)
            StResetPll: begin
                if (force_relock) begin
                    state_d = StResetPll;
                end else if (rst_cnt_q == RstW'(RstLast)) begin
                    state_d = StWaitLock;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StWaitLock: begin
                if (force_relock) begin
                    state_d = StResetPll;
                end else if (lock_s && (stable_q == StableW'(StableLast))) begin
                    state_d = StRelease;
                end else if (timeout_q == TimeoutW'(TimeoutLast)) begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = (retry_q == RetryW'(MAX_RETRIES - 1)) ? StFault : StResetPll;
                end else begin
                    stable_d  = lock_s ? stable_q + StableW'(1) : '0;
                    timeout_d = timeout_q + TimeoutW'(1);
                end
            end
            StRelease, StRun: begin
                if (force_relock) begin
                    state_d = StResetPll;
                end else if (loss_hit) begin
                    loss_cnt_d = (loss_cnt_q == '1) ? loss_cnt_q : loss_cnt_q + CNT_W'(1);
                    state_d    = StResetPll;
                end else begin
                    loss_filt_d = lock_s ? '0 : loss_filt_q + LossW'(1);
                    if (state_q == StRelease) begin
                        if (rel_cnt_q == RelW'(RelLast)) begin
                            state_d = StRun;
                            retry_d = '0;
                        end else begin
                            rel_cnt_d = rel_cnt_q + RelW'(1);
                        end
                    end
                end
            end
            StFault: begin
                if (force_relock) begin
                    state_d = StResetPll;
                    retry_d = '0;
                end
            end
            default: state_d = StResetPll;
        endcase
    end

    // Outputs are computed from the next state so they register together with it.
    always_comb begin
        pll_rst_d    = (state_d == StResetPll) || (state_d == StFault);
        ready_d      = (state_d == StRun);
        fault_d      = (state_d == StFault);
        domain_rst_d = '1;
        for (int unsigned i = 0; i < N_RST; i++) begin
            if (state_d == StRelease) begin
                domain_rst_d[i] = 32'(rel_cnt_d) < i * RELEASE_GAP;
            end else begin
                domain_rst_d[i] = (state_d != StRun);
            end
        end
    end

    assign retry_count = retry_q;
    assign loss_count  = loss_cnt_q;
    assign state_o     = state_q;

endmodule
